// File: rtl/ifetch_pkg.sv
// Definitions shared by the fetch stage and the pipeline registers that sit
// downstream of it: bus width, default reset PC / bubble word and FSM encoding.
package ifetch_pkg;

   localparam int BUS_W = 32;

   localparam logic [BUS_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [BUS_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      MISS  = 2'd1,
      KILL  = 2'd2
   } fetch_state_t;

   // Word-granular PC increment; wraps modulo 2^30 words (i.e. 2^32 bytes).
   function automatic logic [BUS_W-3:0] next_word(input logic [BUS_W-3:0] word);
      return word + 30'd1;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with hold (freeze) and flush (bubble) controls.
// Hold wins over flush; otherwise the incoming pair is captured as valid.
module ifid_reg
   import ifetch_pkg::*;
#(
   parameter int          W   = BUS_W,
   parameter logic [W-1:0] NOP = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         flush,
   input  logic [W-1:0] load_instr,
   input  logic [W-1:0] load_pc,
   output logic [W-1:0] instr,
   output logic [W-1:0] pc,
   output logic         valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr <= NOP;
         pc    <= '0;
         valid <= 1'b0;
      end else if (hold) begin
         instr <= instr;
      end else if (flush) begin
         instr <= NOP;
         pc    <= '0;
         valid <= 1'b0;
      end else begin
         instr <= load_instr;
         pc    <= load_pc;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/ifetch_stage.sv
// MIPS instruction-fetch stage: PC, I-cache request, redirects and miss FSM.
// Optional IFETCH_PERF_CNT_EN adds saturating fetch/miss counters.
module ifetch_stage
   import ifetch_pkg::*;
#(
   parameter logic [BUS_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [BUS_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        Jump,
   input  logic [31:0] jump_target,
   input  logic        isJR,
   input  logic [31:0] jr_target,
   output logic        ICACHE_ren,
   output logic [29:0] ICACHE_addr,
   input  logic [31:0] ICACHE_rdata,
   input  logic        ICACHE_stall,
   output logic [31:0] Instruction,
   output logic [31:0] PC_plus4,
   output logic        if_valid
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] miss_cnt
`endif
);

   fetch_state_t state_reg;
   logic [29:0]  pc_reg;
   logic [29:0]  pend_reg;
   logic [29:0]  target;
   logic         redirect;
   logic         ifid_hold;
   logic         ifid_flush;
   logic         unused_target_bits;

   // PC[1:0] is architecturally zero, so redirect targets are kept word-aligned.
   assign unused_target_bits = ^{branch_target[1:0], jump_target[1:0], jr_target[1:0]};

   assign redirect = (branch_taken | isJR | Jump) & ~stall;

   always_comb begin
      target = jump_target[31:2];
      if (branch_taken)
         target = branch_target[31:2];
      else if (isJR)
         target = jr_target[31:2];
   end

   // While a miss is outstanding or a stale word is being drained, IF/ID only
   // ever holds (decode stalled) or takes a bubble.
   always_comb begin
      ifid_hold  = stall;
      ifid_flush = 1'b0;
      if (ICACHE_stall || state_reg == KILL)
         ifid_flush = ~stall;
      else
         ifid_flush = redirect;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= FETCH;
         pc_reg    <= RESET_PC[31:2];
         pend_reg  <= '0;
      end else begin
         case (state_reg)
            FETCH, MISS: begin
               if (!ICACHE_stall) begin
                  state_reg <= FETCH;
                  if (redirect)
                     pc_reg <= target;
                  else if (!stall)
                     pc_reg <= next_word(pc_reg);
               end else if (redirect) begin
                  pend_reg  <= target;
                  state_reg <= KILL;
               end else begin
                  state_reg <= MISS;
               end
            end
            KILL: begin
               // The address stays on the stale request until the cache lets go.
               if (!ICACHE_stall) begin
                  pc_reg    <= redirect ? target : pend_reg;
                  state_reg <= FETCH;
               end else if (redirect) begin
                  pend_reg <= target;
               end
            end
            default: state_reg <= FETCH;
         endcase
      end
   end

   assign ICACHE_ren  = ~rst;
   assign ICACHE_addr = pc_reg;

   ifid_reg #(
      .W   (BUS_W),
      .NOP (NOP_WORD)
   ) u_ifid (
      .clk        (clk),
      .rst        (rst),
      .hold       (ifid_hold),
      .flush      (ifid_flush),
      .load_instr (ICACHE_rdata),
      .load_pc    ({next_word(pc_reg), 2'b00}),
      .instr      (Instruction),
      .pc         (PC_plus4),
      .valid      (if_valid)
   );

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_reg;
   logic [31:0] miss_cnt_reg;
   logic        accept_word;
   logic        miss_cycle;

   assign accept_word = ~ICACHE_stall & (state_reg != KILL) & ~ifid_hold & ~ifid_flush;
   assign miss_cycle  = (state_reg != FETCH) | ICACHE_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_reg <= '0;
         miss_cnt_reg  <= '0;
      end else begin
         if (accept_word && fetch_cnt_reg != 32'hFFFF_FFFF)
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
         if (miss_cycle && miss_cnt_reg != 32'hFFFF_FFFF)
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_reg;
   assign miss_cnt  = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: combinational cache model returning
// word address + 1, directed redirect/stall/miss/wrap/reset sequences.
module tb_ifetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        Jump;
   logic [31:0] jump_target;
   logic        isJR;
   logic [31:0] jr_target;
   logic        ICACHE_ren;
   logic [29:0] ICACHE_addr;
   logic [31:0] ICACHE_rdata;
   logic        ICACHE_stall;
   logic [31:0] Instruction;
   logic [31:0] PC_plus4;
   logic        if_valid;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       tag;
      logic [31:0] instr;
      logic        valid;
      logic [31:0] pc4;
      logic [29:0] addr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [29:0] a);
      return {2'b00, a} + 32'd1;
   endfunction

   assign ICACHE_rdata = word_at(ICACHE_addr);

   ifetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .Jump          (Jump),
      .jump_target   (jump_target),
      .isJR          (isJR),
      .jr_target     (jr_target),
      .ICACHE_ren    (ICACHE_ren),
      .ICACHE_addr   (ICACHE_addr),
      .ICACHE_rdata  (ICACHE_rdata),
      .ICACHE_stall  (ICACHE_stall),
      .Instruction   (Instruction),
      .PC_plus4      (PC_plus4),
      .if_valid      (if_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic cs, input logic br, input logic jr,
                        input logic jp, input logic [31:0] bt, input logic [31:0] rt,
                        input logic [31:0] jt);
      stall         = st;
      ICACHE_stall  = cs;
      branch_taken  = br;
      isJR          = jr;
      Jump          = jp;
      branch_target = bt;
      jr_target     = rt;
      jump_target   = jt;
   endtask

   // Push the expected IF/ID and next address, clock once, pop and compare.
   task automatic tick(input string tag, input logic [31:0] e_instr, input logic e_valid,
                       input logic [31:0] e_pc4, input logic [29:0] e_addr);
      exp_t e;
      e.tag   = tag;
      e.instr = e_instr;
      e.valid = e_valid;
      e.pc4   = e_pc4;
      e.addr  = e_addr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".instr"}, Instruction, e.instr);
      check({e.tag, ".valid"}, {31'b0, if_valid}, {31'b0, e.valid});
      if (e.valid)
         check({e.tag, ".pc4"}, PC_plus4, e.pc4);
      check({e.tag, ".addr"}, {2'b00, ICACHE_addr}, {2'b00, e.addr});
      check({e.tag, ".ren"}, {31'b0, ICACHE_ren}, 32'd1);
      $display("txn %-10s addr=%h instr=%h pc4=%h valid=%b", e.tag, ICACHE_addr,
               Instruction, PC_plus4, if_valid);
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".instr"}, Instruction, 32'h0);
      check({tag, ".valid"}, {31'b0, if_valid}, 32'd0);
      check({tag, ".pc4"}, PC_plus4, 32'h0);
      check({tag, ".addr"}, {2'b00, ICACHE_addr}, 32'h0);
      check({tag, ".ren"}, {31'b0, ICACHE_ren}, 32'd0);
      $display("txn %-10s addr=%h instr=%h pc4=%h valid=%b ren=%b", tag, ICACHE_addr,
               Instruction, PC_plus4, if_valid, ICACHE_ren);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      #1;
      check_reset("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // straight-line hits
      tick("hit0", 32'd1, 1'b1, 32'd4, 30'd1);
      tick("hit1", 32'd2, 1'b1, 32'd8, 30'd2);

      // taken branch on a hit
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
      tick("br_hit", 32'h0, 1'b0, 32'h0, 30'h10);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("after_br", 32'h11, 1'b1, 32'h44, 30'h11);

      // stall masks a pending jump, then the jump is taken
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h300);
      tick("stall_j0", 32'h11, 1'b1, 32'h44, 30'h11);
      tick("stall_j1", 32'h11, 1'b1, 32'h44, 30'h11);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h300);
      tick("jump", 32'h0, 1'b0, 32'h0, 30'hC0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("after_j", 32'hC1, 1'b1, 32'h304, 30'hC1);

      // target priority branch > JR > jump
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 32'h600, 32'h700);
      tick("prio_br", 32'h0, 1'b0, 32'h0, 30'h140);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h600, 32'h700);
      tick("prio_jr", 32'h0, 1'b0, 32'h0, 30'h180);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("after_jr", 32'h181, 1'b1, 32'h604, 30'h181);

      // redirects during a four-cycle miss; newest redirect wins
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("miss1", 32'h0, 1'b0, 32'h0, 30'h181);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0);
      tick("miss2_jr", 32'h0, 1'b0, 32'h0, 30'h181);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0);
      tick("miss3_br", 32'h0, 1'b0, 32'h0, 30'h181);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("miss4", 32'h0, 1'b0, 32'h0, 30'h181);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("kill_done", 32'h0, 1'b0, 32'h0, 30'h80);
      tick("after_kill", 32'h81, 1'b1, 32'h204, 30'h81);

      // decode stall during a miss and on a hit holds IF/ID
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("miss_stall", 32'h81, 1'b1, 32'h204, 30'h81);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("hit_stall", 32'h81, 1'b1, 32'h204, 30'h81);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("resume", 32'h82, 1'b1, 32'h208, 30'h82);

      // plain miss then hit
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("plain_miss", 32'h0, 1'b0, 32'h0, 30'h82);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("miss_hit", 32'h83, 1'b1, 32'h20C, 30'h83);

      // unaligned jump target to the top word, then PC wraps to 0
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF);
      tick("j_top", 32'h0, 1'b0, 32'h0, 30'h3FFF_FFFF);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("wrap", 32'h4000_0000, 1'b1, 32'h0, 30'h0);
      tick("hit_zero", 32'd1, 1'b1, 32'd4, 30'd1);

      // asynchronous reset while in KILL drops the pending redirect
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h0);
      tick("to_kill", 32'h0, 1'b0, 32'h0, 30'h1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      check_reset("rst_kill");
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick("post_rst", 32'd1, 1'b1, 32'd4, 30'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
